// File: rtl/bram_sched_pkg.sv
// Shared types for the BRAM port scheduler: the sequencer state and the requester count.
package bram_sched_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

endpackage

// File: rtl/bram_rr_arbiter2.sv
// Two-way round-robin arbiter with a burst lock that pins the grant to one owner.
module bram_rr_arbiter2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] valid_i,
  input  logic [1:0] accept_i,
  input  logic [1:0] lock_i,
  output logic [1:0] grant_o,
  output logic       locked_o
);

  logic ptr_q;
  logic owner_q;
  logic locked_q;
  logic other_ptr;
  logic acc_g;

  assign other_ptr = ~ptr_q;
  assign acc_g     = accept_i[1];
  assign locked_o  = locked_q;

  // A locked owner keeps the port even while idle; nobody else may take it.
  always_comb begin
    grant_o = '0;
    if (locked_q) begin
      grant_o[owner_q] = valid_i[owner_q];
    end else if (valid_i[ptr_q]) begin
      grant_o[ptr_q] = 1'b1;
    end else if (valid_i[other_ptr]) begin
      grant_o[other_ptr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q    <= 1'b0;
      owner_q  <= 1'b0;
      locked_q <= 1'b0;
    end else if (|accept_i) begin
      locked_q <= lock_i[acc_g];
      owner_q  <= acc_g;
      if (!lock_i[acc_g]) begin
        ptr_q <= ~acc_g;
      end
    end
  end

endmodule

// File: rtl/bram_port_scheduler.sv
// Init sweep sequencer plus two-requester arbiter and port mux for one BRAM port.
module bram_port_scheduler
  import bram_sched_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush,
  output logic                          init_busy,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wrten,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          bram_en,
  output logic [DATA_WIDTH/8-1:0]       bram_write_en,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic [DATA_WIDTH-1:0]         bram_data_in,
  input  logic [DATA_WIDTH-1:0]         bram_data_out
);

  localparam int BE_W = DATA_WIDTH / 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [BE_W-1:0]       wrten;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  lock;
  } req_t;

  req_t                  req [NUM_REQ];
  logic [NUM_REQ-1:0]    lock_vec;
  sched_state_t          state_q;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic                  run;
  logic                  locked;
  logic                  flush_take;
  logic [NUM_REQ-1:0]    arb_valid;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    accept;
  logic                  gsel;
  logic                  is_read;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req[i] = '{addr:  req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                      wrten: req_wrten[i*BE_W +: BE_W],
                      wdata: req_wdata[i*DATA_WIDTH +: DATA_WIDTH],
                      lock:  req_lock[i]};
    assign lock_vec[i] = req[i].lock;
  end

  assign run        = (state_q == RUN);
  assign arb_valid  = run ? req_valid : '0;
  // A flush arriving mid-burst waits until the lock has been released.
  assign flush_take = run && !locked && (flush || flush_pend_q);

  bram_rr_arbiter2 u_arb (
    .clk      (clk),
    .resetn   (resetn),
    .valid_i  (arb_valid),
    .accept_i (accept),
    .lock_i   (lock_vec),
    .grant_o  (grant),
    .locked_o (locked)
  );

  assign req_ready  = flush_take ? '0 : grant;
  assign accept     = req_valid & req_ready;
  assign gsel       = grant[1];
  assign is_read    = (req[gsel].wrten == '0);
  assign init_busy  = !run;
  assign resp_valid = resp_valid_q;
  assign resp_data  = bram_data_out;

  always_comb begin
    bram_en       = 1'b0;
    bram_write_en = '0;
    bram_addr     = req[gsel].addr;
    bram_data_in  = req[gsel].wdata;
    if (!run) begin
      bram_en       = 1'b1;
      bram_write_en = '1;
      bram_addr     = cnt_q;
      bram_data_in  = INIT_VALUE;
    end else if (|accept) begin
      bram_en       = 1'b1;
      bram_write_en = req[gsel].wrten;
    end
  end

  always_comb begin
    cnt_d        = run ? cnt_q : cnt_q + 1'b1;
    flush_pend_d = flush_take ? 1'b0 : (flush_pend_q || (run && flush && locked));
    resp_valid_d = accept & {NUM_REQ{is_read}};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      resp_valid_q <= resp_valid_d;
      case (state_q)
        INIT: if (cnt_q == '1) state_q <= RUN;
        RUN:  if (flush_take) state_q <= INIT;
        default: state_q <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_port_scheduler.sv
// Directed bench for bram_port_scheduler with a write-first, byte-enabled BRAM model.
module tb_bram_port_scheduler;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = DW / 8;

  logic            clk;
  logic            resetn;
  logic            flush;
  logic            init_busy;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [2*AW-1:0] req_addr;
  logic [2*BW-1:0] req_wrten;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      req_lock;
  logic [1:0]      resp_valid;
  logic [DW-1:0]   resp_data;
  logic            bram_en;
  logic [BW-1:0]   bram_write_en;
  logic [AW-1:0]   bram_addr;
  logic [DW-1:0]   bram_data_in;
  logic [DW-1:0]   bram_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  bram_port_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE('0)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .flush         (flush),
    .init_busy     (init_busy),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_wrten     (req_wrten),
    .req_wdata     (req_wdata),
    .req_lock      (req_lock),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .bram_en       (bram_en),
    .bram_write_en (bram_write_en),
    .bram_addr     (bram_addr),
    .bram_data_in  (bram_data_in),
    .bram_data_out (bram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [1<<AW];
  initial bram_data_out = '0;
  always @(posedge clk) begin : bram_model
    logic [DW-1:0] w;
    if (bram_en) begin
      w = mem[bram_addr];
      for (int b = 0; b < BW; b++)
        if (bram_write_en[b]) w[8*b +: 8] = bram_data_in[8*b +: 8];
      mem[bram_addr] <= w;
      bram_data_out  <= w;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] d, input logic lk);
    req_valid[r]            = v;
    req_addr[r*AW +: AW]    = a;
    req_wrten[r*BW +: BW]   = be;
    req_wdata[r*DW +: DW]   = d;
    req_lock[r]             = lk;
  endtask

  task automatic wait_ready(input int r, input string tag);
    int n;
    n = 0;
    #1;
    while (!req_ready[r] && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_ready"}, 64'(req_ready[r]), 64'd1);
  endtask

  task automatic write_beat(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [BW-1:0] be, input string tag);
    set_req(r, 1'b1, a, be, d, 1'b0);
    wait_ready(r, tag);
    @(negedge clk);
    set_req(r, 1'b0, '0, '0, '0, 1'b0);
    chk({tag, "_noresp"}, 64'(resp_valid[r]), 64'd0);
  endtask

  task automatic read_chk(input int r, input logic [AW-1:0] a, input logic [DW-1:0] exp,
                          input string tag);
    set_req(r, 1'b1, a, '0, '0, 1'b0);
    wait_ready(r, tag);
    @(negedge clk);
    set_req(r, 1'b0, '0, '0, '0, 1'b0);
    chk({tag, "_rvalid"}, 64'(resp_valid[r]), 64'd1);
    chk({tag, "_rdata"}, 64'(resp_data), 64'(exp));
  endtask

  // Called on the negedge where the sweep's counter is 0.
  task automatic sweep_chk(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      if (!(bram_en === 1'b1 && bram_write_en === '1 && bram_addr === AW'(i) &&
            bram_data_in === '0 && init_busy === 1'b1 && req_ready === 2'b00))
        bad++;
      @(negedge clk);
    end
    chk({tag, "_bad_cycles"}, 64'(bad), 64'd0);
    chk({tag, "_done"}, 64'(init_busy), 64'd0);
  endtask

  initial begin
    int n;
    resetn = 1'b0; flush = 1'b0;
    req_valid = '0; req_addr = '0; req_wrten = '0; req_wdata = '0; req_lock = '0;

    #2;
    chk("rst_init_busy", 64'(init_busy), 64'd1);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_bram_en", 64'(bram_en), 64'd1);
    chk("rst_bram_addr", 64'(bram_addr), 64'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Initial sweep then readback of the top address.
    sweep_chk("sweep1");
    read_chk(0, 10'h3FF, 32'h0, "rd_3ff");

    // Contention: alternating grants with per-requester responses.
    write_beat(0, 10'h10, 32'hAAAA0010, 4'hF, "wr10");
    write_beat(1, 10'h20, 32'hBBBB0020, 4'hF, "wr20");
    set_req(0, 1'b1, 10'h10, '0, '0, 1'b0);
    set_req(1, 1'b1, 10'h20, '0, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cont_grant", 64'(req_ready), (k % 2) ? 64'h2 : 64'h1);
      @(negedge clk);
      chk("cont_resp_v", 64'(resp_valid), (k % 2) ? 64'h2 : 64'h1);
      chk("cont_resp_d", 64'(resp_data), (k % 2) ? 64'hBBBB0020 : 64'hAAAA0010);
    end
    set_req(0, 1'b0, '0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, '0, 1'b0);

    // Locked burst from req0 holds off a waiting req1 for four cycles.
    set_req(1, 1'b1, 10'h20, '0, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, AW'(10'h40 + k), 4'hF, 32'hC0DE0000 + k, k < 3);
      #1;
      chk("lock_grant", 64'(req_ready), 64'h1);
      @(negedge clk);
    end
    set_req(0, 1'b0, '0, '0, '0, 1'b0);
    #1;
    chk("lock_release_grant", 64'(req_ready), 64'h2);
    @(negedge clk);
    set_req(1, 1'b0, '0, '0, '0, 1'b0);
    chk("lock_r1_rvalid", 64'(resp_valid), 64'h2);
    chk("lock_r1_rdata", 64'(resp_data), 64'hBBBB0020);
    for (int k = 0; k < 4; k++)
      read_chk(0, AW'(10'h40 + k), 32'hC0DE0000 + k, "lock_rb");

    // Flush on the second beat of a locked burst is deferred until the burst ends.
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, AW'(10'h50 + k), 4'hF, 32'h5A5A0000 + k, k < 3);
      flush = (k == 1);
      #1;
      chk("flock_grant", 64'(req_ready), 64'h1);
      chk("flock_busy", 64'(init_busy), 64'd0);
      @(negedge clk);
      flush = 1'b0;
    end
    set_req(0, 1'b1, 10'h50, '0, '0, 1'b0);
    #1;
    chk("flush_take_ready", 64'(req_ready), 64'd0);
    chk("flush_take_busy", 64'(init_busy), 64'd0);
    @(negedge clk);
    set_req(0, 1'b0, '0, '0, '0, 1'b0);
    chk("flush_init_busy", 64'(init_busy), 64'd1);
    sweep_chk("sweep2");
    read_chk(0, 10'h50, 32'h0, "flush_rb50");
    read_chk(1, 10'h41, 32'h0, "flush_rb41");

    // Read-after-write with partial byte enables.
    write_beat(0, 10'h5, 32'hDEADBEEF, 4'hF, "raw_w1");
    write_beat(0, 10'h5, 32'h00000011, 4'h1, "raw_w2");
    read_chk(0, 10'h5, 32'hDEADBE11, "raw_rd");

    // Flush while idle, flush ignored during INIT, then async reset mid-sweep.
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush2_busy", 64'(init_busy), 64'd1);
    n = 0;
    while (bram_addr !== AW'(100) && n < 2000) begin @(negedge clk); n++; end
    chk("wait_addr100", 64'(bram_addr), 64'd100);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_init_addr", 64'(bram_addr), 64'd101);
    n = 0;
    while (bram_addr !== AW'(500) && n < 2000) begin @(negedge clk); n++; end
    chk("wait_addr500", 64'(bram_addr), 64'd500);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_addr", 64'(bram_addr), 64'd0);
    chk("arst_busy", 64'(init_busy), 64'd1);
    chk("arst_ready", 64'(req_ready), 64'd0);
    chk("arst_resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    chk("arst_rel_addr0", 64'(bram_addr), 64'd0);
    @(negedge clk);
    chk("arst_rel_addr1", 64'(bram_addr), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
